// File: rtl/uart_receiver_os.sv
// rtl/uart_receiver_os.sv - oversampled UART receiver with parity, stop-bit count and framing checks
// Optional 2-of-3 majority bit sampling is enabled by defining UART_RX_MAJORITY_EN.
module uart_receiver_os #(
    parameter int DATA_WIDTH  = 8,
    parameter int OVERSAMPLE  = 16,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1
) (
    input  logic                  clk,
    input  logic                  rstN,
    input  logic                  baudTick,
    input  logic                  rx,
    output logic                  rx_ready,
    output logic [DATA_WIDTH-1:0] dataOut,
    output logic                  new_byte_indicate,
    output logic                  parity_err,
    output logic                  frame_err
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = 4;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK} state_t;

    logic samp;

`ifdef UART_RX_MAJORITY_EN
    // The majority window ends one tick after the nominal mid point, so every decision moves one tick later.
    localparam int START_PT = OVERSAMPLE / 2;
    logic [1:0] hist_q, hist_d;

    assign hist_d = baudTick ? {hist_q[0], rx} : hist_q;
    assign samp   = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx) | (hist_q[0] & rx);

    always_ff @(posedge clk) begin
        if (!rstN) hist_q <= 2'b11;
        else       hist_q <= hist_d;
    end
`else
    localparam int START_PT = OVERSAMPLE / 2 - 1;
    assign samp = rx;
`endif

    state_t                state_q, state_d;
    logic [TW-1:0]         tick_q, tick_d;
    logic [BW-1:0]         bit_q, bit_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  perr_q, perr_d;
    logic                  ferr_q, ferr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  perr_out_q, perr_out_d;
    logic                  ferr_out_q, ferr_out_d;
    logic                  pulse_q, pulse_d;
    logic                  bit_end;

    assign bit_end = (tick_q == TW'(OVERSAMPLE - 1));

    always_comb begin
        state_d    = state_q;
        tick_d     = tick_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        data_d     = data_q;
        perr_out_d = perr_out_q;
        ferr_out_d = ferr_out_q;
        pulse_d    = 1'b0;
        if (baudTick) begin
            case (state_q)
                IDLE: begin
                    if (!rx) begin
                        state_d = START;
                        tick_d  = '0;
                    end
                end
                START: begin
                    if (tick_q == TW'(START_PT)) begin
                        if (!samp) begin
                            state_d = DATA;
                            tick_d  = '0;
                            bit_d   = '0;
                            perr_d  = 1'b0;
                            ferr_d  = 1'b0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
                DATA, PARITY, STOP: begin
                    if (!bit_end) begin
                        tick_d = tick_q + TW'(1);
                    end else begin
                        tick_d = '0;
                        if (state_q == DATA) begin
                            shift_d = {samp, shift_q[DATA_WIDTH-1:1]};
                            if (bit_q == BW'(DATA_WIDTH - 1)) begin
                                bit_d   = '0;
                                state_d = (PARITY_MODE != 0) ? PARITY : STOP;
                            end else begin
                                bit_d = bit_q + BW'(1);
                            end
                        end else if (state_q == PARITY) begin
                            perr_d  = (PARITY_MODE == 2) ? ~(^shift_q ^ samp) : (^shift_q ^ samp);
                            state_d = STOP;
                        end else begin
                            ferr_d = ferr_q | ~samp;
                            if (bit_q == BW'(STOP_BITS - 1)) begin
                                data_d     = shift_q;
                                perr_out_d = perr_q;
                                ferr_out_d = ferr_d;
                                pulse_d    = 1'b1;
                                state_d    = ferr_d ? BRK : IDLE;
                            end else begin
                                bit_d = bit_q + BW'(1);
                            end
                        end
                    end
                end
                BRK: begin
                    // A held-low line must go high before another start bit is accepted.
                    if (rx) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rstN) begin
            state_q    <= IDLE;
            tick_q     <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            data_q     <= '0;
            perr_out_q <= 1'b0;
            ferr_out_q <= 1'b0;
            pulse_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_q     <= tick_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            data_q     <= data_d;
            perr_out_q <= perr_out_d;
            ferr_out_q <= ferr_out_d;
            pulse_q    <= pulse_d;
        end
    end

    assign rx_ready          = (state_q == IDLE);
    assign dataOut           = data_q;
    assign new_byte_indicate = pulse_q;
    assign parity_err        = perr_out_q;
    assign frame_err         = ferr_out_q;

endmodule

// File: doc/uart_receiver_os.md
Name: uart_receiver_os

Overview:
- Parametrised successor to the single-mode UART receiver: oversampled serial-to-parallel receiver with configurable data width, parity mode and stop-bit count.
- Reports parity and framing errors and rejects false start bits.
- Sits between the pad-side rx line and the byte consumer (loader/FIFO), driven by the shared baud-rate generator running at BAUD_RATE*OVERSAMPLE.

Parameters:
DATA_WIDTH, 8, data bits per frame (5..9), LSB first
OVERSAMPLE, 16, baudTick pulses per bit period (even, 8..32)
PARITY_MODE, 0, 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, stop bits expected (1 or 2)

Ports:
clk  input  1  system clock
rstN  input  1  synchronous active-low reset, sampled on posedge clk
baudTick  input  1  one-clk pulse at BAUD_RATE*OVERSAMPLE
rx  input  1  serial line, idle high
rx_ready  output  1  high while receiver is IDLE (no frame in progress)
dataOut  output  DATA_WIDTH  last received data word, held until next frame completes
new_byte_indicate  output  1  one-clk pulse when a frame completes
parity_err  output  1  parity mismatch on last frame; valid with the pulse, held
frame_err  output  1  a stop bit sampled low on last frame; valid with the pulse, held

Behaviour:
- Reset: rstN low at posedge clk -> state IDLE, tick/bit counters 0, shift register 0. Outputs: dataOut 0, new_byte_indicate 0, parity_err 0, frame_err 0, rx_ready 1. Reset mid-frame aborts the frame with no pulse.
- All sampling occurs only on clk edges where baudTick = 1. The tick counter counts 0..OVERSAMPLE-1 and wraps.
- IDLE: on a tick with rx = 0 -> START, tick counter cleared. rx_ready = 0 in every state except IDLE.
- START: at tick count OVERSAMPLE/2-1 (mid start bit), rx = 0 -> DATA with counters cleared. rx = 1 is a false start -> IDLE, no pulse, flags unchanged.
- DATA: every OVERSAMPLE ticks (mid-bit), shift rx into the MSB and shift right, so the first bit received becomes dataOut[0]. After DATA_WIDTH samples -> PARITY if PARITY_MODE != 0, else STOP.
- PARITY: sample one bit at mid-bit. Even mode: error if XOR(data, bit) = 1. Odd mode: error if XOR(data, bit) = 0. The result is captured internally -> STOP.
- STOP: sample STOP_BITS bits at mid-bit. Any low sample sets the internal frame error. After the last stop sample, on the same clk edge:
  - dataOut <= shift register
  - parity_err and frame_err <= internal results
  - new_byte_indicate <= 1 for exactly one clk
  - Next state: IDLE if no frame error, else BREAK.
- BREAK: wait for rx = 1 on a tick -> IDLE. This prevents a held-low line (break) from re-triggering frames.
- Latency: the pulse arrives in the clk cycle after the baudTick that samples the final stop bit mid-bit, i.e. about half a bit before the nominal end of the frame.
- Pulse width is 1 clk regardless of clock/baud ratio. The next frame's start bit may be detected on the first tick after returning to IDLE.
- dataOut and both flags change only with a pulse or a reset.

Optional Feature:
- Macro UART_RX_MAJORITY_EN.
- Defined: every bit sample (start, data, parity, stop) is the 2-of-3 majority of rx at tick counts mid-1, mid and mid+1, where mid is the sample point above. A single-tick glitch is therefore ignored, including within false-start detection.
- Undefined: single sample at mid. No extra registers are added.

Test Plan:
- Reset then idle: rstN low 2 clk, rx = 1 -> rx_ready = 1, dataOut = 0, no pulse for 5 bit periods.
- 8N1, OVERSAMPLE 16, send 0xA5 -> one pulse, dataOut = 0xA5, parity_err = 0, frame_err = 0. Then send 0x3C back-to-back -> second pulse, dataOut = 0x3C.
- PARITY_MODE = 1 (even): send 0x07 with parity bit 1 -> parity_err = 0. Send 0x07 with parity bit 0 -> parity_err = 1, dataOut = 0x07.
- STOP_BITS = 2: send 0x55 with second stop bit low -> pulse, frame_err = 1. rx held low for 3 frames -> no further pulse until rx returns high; then 0x12 -> frame_err = 0.
- False start: rx low for 4 ticks then high -> no pulse, returns to IDLE (rx_ready = 1). With UART_RX_MAJORITY_EN, a 1-tick low glitch at mid data bit of 0xFF -> dataOut = 0xFF.
- Reset mid-frame: assert rstN at data bit 4 of 0x81 -> no pulse, outputs at reset values. The next full 0x81 frame is received correctly.
